cond_unit: RTL and testbench

Conditional-execution stage that sits directly after the ALU and consumes its Negative/Zero/Carry/OverFlow flags. It holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against the flags left by earlier instructions. It gates the instruction's write and branch controls and updates the flags only when the instruction executes. Results are presented to the writeback/fetch logic through a one-entry valid/ready output register.

---
 rtl/cond_unit.sv | 131 +++++++++++++
 tb/tb_cond_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Conditional-execution stage: holds NZCV, evaluates ARM condition codes,
// gates write/branch controls and registers the result behind valid/ready.
module cond_unit #(
    parameter logic [3:0] NZCV_RST = 4'b0000,
    parameter int         SQ_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            InValid,
    output logic            InReady,
    input  logic [3:0]      Cond,
    input  logic [1:0]      FlagWrite,
    input  logic            RegWriteIn,
    input  logic            MemWriteIn,
    input  logic            PCSrcIn,
    input  logic            Negative,
    input  logic            Zero,
    input  logic            Carry,
    input  logic            OverFlow,
    input  logic            Flush,
    output logic            OutValid,
    input  logic            OutReady,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic            PCSrc,
    output logic            CondEx,
    output logic [3:0]      Flags,
    output logic [SQ_W-1:0] SquashCount
);

    logic            ov_q, ov_d;
    logic            rw_q, rw_d;
    logic            mw_q, mw_d;
    logic            pc_q, pc_d;
    logic            ce_q, ce_d;
    logic [3:0]      fl_q, fl_d;
    logic [SQ_W-1:0] sq_q, sq_d;
    logic            accept;
    logic            ce;
    logic            n, z, c, v;

    assign {n, z, c, v} = fl_q;
    assign InReady = !ov_q | OutReady;
    assign accept  = InValid & InReady & !Flush;

    // Evaluated against the registered flags, never the ALU inputs
    always_comb begin
        ce = 1'b1;
        unique case (Cond)
            4'b0000: ce = z;
            4'b0001: ce = !z;
            4'b0010: ce = c;
            4'b0011: ce = !c;
            4'b0100: ce = n;
            4'b0101: ce = !n;
            4'b0110: ce = v;
            4'b0111: ce = !v;
            4'b1000: ce = c & !z;
            4'b1001: ce = !c | z;
            4'b1010: ce = (n == v);
            4'b1011: ce = (n != v);
            4'b1100: ce = !z & (n == v);
            4'b1101: ce = z | (n != v);
            default: ce = 1'b1;
        endcase
    end

    always_comb begin
        ov_d = ov_q;
        rw_d = rw_q;
        mw_d = mw_q;
        pc_d = pc_q;
        ce_d = ce_q;
        fl_d = fl_q;
        sq_d = sq_q;
        if (Flush) begin
            ov_d = 1'b0;
            rw_d = 1'b0;
            mw_d = 1'b0;
            pc_d = 1'b0;
            ce_d = 1'b0;
        end else if (accept) begin
            ov_d = 1'b1;
            ce_d = ce;
            rw_d = RegWriteIn & ce;
            mw_d = MemWriteIn & ce;
            pc_d = PCSrcIn & ce;
            if (ce) begin
                if (FlagWrite[1]) fl_d[3:2] = {Negative, Zero};
                if (FlagWrite[0]) fl_d[1:0] = {Carry, OverFlow};
            end else if (sq_q != {SQ_W{1'b1}}) begin
                sq_d = sq_q + {{(SQ_W-1){1'b0}}, 1'b1};
            end
        end else if (ov_q & OutReady) begin
            ov_d = 1'b0;
            rw_d = 1'b0;
            mw_d = 1'b0;
            pc_d = 1'b0;
            ce_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
            rw_q <= 1'b0;
            mw_q <= 1'b0;
            pc_q <= 1'b0;
            ce_q <= 1'b0;
            fl_q <= NZCV_RST;
            sq_q <= '0;
        end else begin
            ov_q <= ov_d;
            rw_q <= rw_d;
            mw_q <= mw_d;
            pc_q <= pc_d;
            ce_q <= ce_d;
            fl_q <= fl_d;
            sq_q <= sq_d;
        end
    end

    assign OutValid    = ov_q;
    assign RegWrite    = rw_q;
    assign MemWrite    = mw_q;
    assign PCSrc       = pc_q;
    assign CondEx      = ce_q;
    assign Flags       = fl_q;
    assign SquashCount = sq_q;

endmodule

// File: tb/tb_cond_unit.sv
// Testbench for cond_unit: directed plan steps plus random traffic
// checked against a behavioural model of the stage.
module tb_cond_unit;

    localparam int         SQ_W = 4;
    localparam logic [3:0] RSTF = 4'b0000;
    localparam int         SQ_MAX = (1 << SQ_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            InValid, InReady;
    logic [3:0]      Cond;
    logic [1:0]      FlagWrite;
    logic            RegWriteIn, MemWriteIn, PCSrcIn;
    logic            Negative, Zero, Carry, OverFlow;
    logic            Flush, OutValid, OutReady;
    logic            RegWrite, MemWrite, PCSrc, CondEx;
    logic [3:0]      Flags;
    logic [SQ_W-1:0] SquashCount;

    int total = 0;
    int bad   = 0;

    bit       m_ov, m_rw, m_mw, m_pc, m_ce;
    bit [3:0] m_fl;
    int       m_sq;

    always #5 clk = ~clk;

    cond_unit #(.NZCV_RST(RSTF), .SQ_W(SQ_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .InValid(InValid), .InReady(InReady),
        .Cond(Cond), .FlagWrite(FlagWrite),
        .RegWriteIn(RegWriteIn), .MemWriteIn(MemWriteIn),
        .PCSrcIn(PCSrcIn),
        .Negative(Negative), .Zero(Zero),
        .Carry(Carry), .OverFlow(OverFlow),
        .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .PCSrc(PCSrc),
        .CondEx(CondEx), .Flags(Flags), .SquashCount(SquashCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ARM conditions come in pairs; the odd member is the inverse
    function automatic bit cond_ok(input bit [3:0] c, input bit [3:0] f);
        bit n, z, cy, v, r;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: return 1'b1;
        endcase
        return r ^ c[0];
    endfunction

    task automatic model_reset();
        m_ov = 0; m_rw = 0; m_mw = 0; m_pc = 0; m_ce = 0;
        m_fl = RSTF;
        m_sq = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ov"}, 32'(OutValid), 32'(m_ov));
        chk({tag, ".rw"}, 32'(RegWrite), 32'(m_rw));
        chk({tag, ".mw"}, 32'(MemWrite), 32'(m_mw));
        chk({tag, ".pc"}, 32'(PCSrc), 32'(m_pc));
        chk({tag, ".ce"}, 32'(CondEx), 32'(m_ce));
        chk({tag, ".fl"}, 32'(Flags), 32'(m_fl));
        chk({tag, ".sq"}, 32'(SquashCount), 32'(m_sq));
    endtask

    // Called #1 after a rising edge; drives, predicts, clocks, checks
    task automatic step(input string tag, input bit inv,
                        input bit [3:0] cond, input bit [1:0] fw,
                        input bit [2:0] ctl, input bit [3:0] alu,
                        input bit fl, input bit ordy);
        bit acc, ce;
        InValid = inv; Cond = cond; FlagWrite = fw;
        {RegWriteIn, MemWriteIn, PCSrcIn} = ctl;
        {Negative, Zero, Carry, OverFlow} = alu;
        Flush = fl; OutReady = ordy;
        #1;
        chk({tag, ".inrdy"}, 32'(InReady), 32'(!m_ov || ordy));
        acc = inv && (!m_ov || ordy) && !fl;
        ce  = cond_ok(cond, m_fl);
        if (fl) begin
            {m_ov, m_rw, m_mw, m_pc, m_ce} = '0;
        end else if (acc) begin
            m_ov = 1;
            m_ce = ce;
            {m_rw, m_mw, m_pc} = ce ? ctl : 3'b000;
            if (ce) begin
                if (fw[1]) m_fl[3:2] = alu[3:2];
                if (fw[0]) m_fl[1:0] = alu[1:0];
            end else begin
                m_sq = (m_sq + 1 > SQ_MAX) ? SQ_MAX : m_sq + 1;
            end
        end else if (m_ov && ordy) begin
            {m_ov, m_rw, m_mw, m_pc, m_ce} = '0;
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        InValid = 0; Cond = 0; FlagWrite = 0;
        RegWriteIn = 0; MemWriteIn = 0; PCSrcIn = 0;
        Negative = 0; Zero = 0; Carry = 0; OverFlow = 0;
        Flush = 0; OutReady = 1;
        model_reset();
        #1;
        chk_all("reset");
        chk("reset.flags", 32'(Flags), 32'(4'b0000));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        step("eq_fail", 1, 4'b0000, 2'b00, 3'b100, 4'b0000, 0, 1);
        chk("eq_fail.ce", 32'(CondEx), 0);
        chk("eq_fail.rw", 32'(RegWrite), 0);
        chk("eq_fail.sq", 32'(SquashCount), 1);

        step("al_set", 1, 4'b1110, 2'b11, 3'b000, 4'b0110, 0, 1);
        chk("al_set.flags", 32'(Flags), 32'(4'b0110));
        step("eq_pass", 1, 4'b0000, 2'b00, 3'b100, 4'b0000, 0, 1);
        chk("eq_pass.rw", 32'(RegWrite), 1);
        chk("eq_pass.ce", 32'(CondEx), 1);

        step("set_n", 1, 4'b1110, 2'b11, 3'b000, 4'b1000, 0, 1);
        step("lt", 1, 4'b1011, 2'b00, 3'b111, 4'b0000, 0, 1);
        chk("lt.ce", 32'(CondEx), 1);
        step("ge", 1, 4'b1010, 2'b11, 3'b111, 4'b0111, 0, 1);
        chk("ge.ce", 32'(CondEx), 0);
        chk("ge.flags", 32'(Flags), 32'(4'b1000));

        step("load", 1, 4'b1110, 2'b00, 3'b101, 4'b0000, 0, 1);
        for (int i = 0; i < 3; i++)
            step("stall", 1, 4'b1110, 2'b11, 3'b010, 4'b0101, 0, 0);
        chk("stall.flags", 32'(Flags), 32'(4'b1000));
        step("release", 1, 4'b1110, 2'b11, 3'b010, 4'b0011, 0, 1);
        chk("release.flags", 32'(Flags), 32'(4'b0011));

        step("flush", 1, 4'b1110, 2'b11, 3'b111, 4'b1100, 1, 1);
        chk("flush.ov", 32'(OutValid), 0);
        chk("flush.flags", 32'(Flags), 32'(4'b0011));

        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom), 4'($urandom), 2'($urandom),
                 3'($urandom), 4'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));

        step("clr", 1, 4'b1110, 2'b11, 3'b000, 4'b0000, 0, 1);
        for (int i = 0; i < SQ_MAX + 3; i++)
            step("sat", 1, 4'b0000, 2'b00, 3'b100, 4'b0000, 0, 1);
        chk("sat.sq", 32'(SquashCount), SQ_MAX);

        InValid = 1; Cond = 4'b1110; FlagWrite = 2'b11;
        {Negative, Zero, Carry, OverFlow} = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("post_rst", 1, 4'b1110, 2'b11, 3'b100, 4'b1010, 0, 1);
        chk("post_rst.flags", 32'(Flags), 32'(4'b1010));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
